// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares one RAM port between the instruction-fetch requester and the data
// requester of the MIPS datapath. The granted request is registered onto the
// RAM bus and held there until the RAM pulses ram_ready. Data has priority.
// A starvation counter forces an instruction grant after STARVE_MAX
// consecutive data grants that completed while a fetch was pending.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   iREN       in   instruction read request
//   iaddr      in   instruction address            [ADDR_W]
//   iwait      out  1 = instruction access not complete (combinational)
//   iload      out  instruction read data (passthrough of ramload)
//   dREN       in   data read request
//   dWEN       in   data write request (wins over dREN)
//   daddr      in   data address                   [ADDR_W]
//   dstore     in   data write value               [DATA_W]
//   dwait      out  1 = data access not complete (combinational)
//   dload      out  data read data (passthrough of ramload)
//   ramREN     out  registered RAM read strobe
//   ramWEN     out  registered RAM write strobe
//   ramaddr    out  registered RAM address         [ADDR_W]
//   ramstore   out  registered RAM write data      [DATA_W]
//   ramload    in   RAM read data                  [DATA_W]
//   ram_ready  in   access complete, 1-cycle pulse
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IGRANT = 2'd1,
        ST_DGRANT = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_ram_ren;
    logic              r_ram_wen;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_store;

    logic              w_i_done;
    logic              w_d_done;
    logic              w_rearb;
    logic [3:0]        w_starve_next;
    state_t            w_arb;

    // Saturating increment of the starvation count.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt >= STARVE_LIM) begin
            return STARVE_LIM;
        end
        return cnt + 4'd1;
    endfunction

    assign w_i_done = (r_state == ST_IGRANT) && ram_ready;
    assign w_d_done = (r_state == ST_DGRANT) && ram_ready;
    assign w_rearb  = (r_state == ST_IDLE) || w_i_done || w_d_done;

    // Count after this edge's update. Arbitration looks at this value so the
    // data grant completing right now is included in the consecutive-grant
    // bound; otherwise one extra data grant would slip in before the forced
    // instruction grant.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_d_done) begin
            w_starve_next = iREN ? sat_inc(r_starve_cnt) : 4'd0;
        end else if (w_i_done) begin
            w_starve_next = 4'd0;
        end
    end

    always_comb begin
        w_arb = ST_IDLE;
        if (iREN && (w_starve_next == STARVE_LIM)) begin
            w_arb = ST_IGRANT;
        end else if (dREN || dWEN) begin
            w_arb = ST_DGRANT;
        end else if (iREN) begin
            w_arb = ST_IGRANT;
        end
    end

    // RAM-side controls are loaded only when a new grant is chosen, so
    // requester inputs moving mid-grant never reach the bus.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_ram_ren    <= 1'b0;
            r_ram_wen    <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_store  <= '0;
        end else begin
            r_starve_cnt <= w_starve_next;
            if (w_rearb) begin
                r_state <= w_arb;
                case (w_arb)
                    ST_IGRANT: begin
                        r_ram_addr <= iaddr;
                        r_ram_ren  <= 1'b1;
                        r_ram_wen  <= 1'b0;
                    end
                    ST_DGRANT: begin
                        r_ram_addr  <= daddr;
                        r_ram_store <= dstore;
                        r_ram_wen   <= dWEN;
                        r_ram_ren   <= !dWEN;
                    end
                    default: begin
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign iwait    = !w_i_done;
    assign dwait    = !w_d_done;
    assign iload    = ramload;
    assign dload    = ramload;
    assign ramREN   = r_ram_ren;
    assign ramWEN   = r_ram_wen;
    assign ramaddr  = r_ram_addr;
    assign ramstore = r_ram_store;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              CLK;
    logic              nRST;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;

    int n_chk;
    int n_pass;

    mem_access_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled 1 time unit later, well away from any edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    string seq_exp;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        nRST      = 1'b0;
        iREN      = 1'b0;
        iaddr     = '0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        ramload   = '0;
        ram_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        step();
        step();
        nRST = 1'b1;
        step();
        step();
        #1;
        chk("idle_ramREN", ramREN, 0);
        chk("idle_iwait", iwait, 1);

        // ram_ready while idle is ignored
        ram_ready = 1'b1;
        ramload   = 32'h5555_5555;
        #1;
        chk("idle_rdy_iwait", iwait, 1);
        chk("idle_rdy_dwait", dwait, 1);
        step();
        ram_ready = 1'b0;
        #1;
        chk("idle_rdy_ramREN", ramREN, 0);

        // Single fetch: strobe at cycle 1, ram_ready at cycle 3
        step();
        iREN  = 1'b1;
        iaddr = 32'h0000_0040;
        step();
        #1;
        chk("if_ramREN_c1", ramREN, 1);
        chk("if_ramWEN_c1", ramWEN, 0);
        chk("if_ramaddr_c1", ramaddr, 32'h40);
        chk("if_iwait_c1", iwait, 1);
        step();
        #1;
        chk("if_iwait_c2", iwait, 1);
        step();
        ram_ready = 1'b1;
        ramload   = 32'h2008_0005;
        iREN      = 1'b0;
        #1;
        chk("if_iwait_c3", iwait, 0);
        chk("if_iload_c3", iload, 32'h2008_0005);
        chk("if_dwait_c3", dwait, 1);
        step();
        ram_ready = 1'b0;
        #1;
        chk("if_ramREN_c4", ramREN, 0);
        chk("if_iwait_c4", iwait, 1);

        // Collision: data first, then fetch with no idle cycle
        iREN  = 1'b1;
        iaddr = 32'h0000_0044;
        dREN  = 1'b1;
        daddr = 32'h0000_0100;
        step();
        #1;
        chk("col_ramaddr_d", ramaddr, 32'h100);
        chk("col_ramREN_d", ramREN, 1);
        ram_ready = 1'b1;
        ramload   = 32'h1234_5678;
        dREN      = 1'b0;
        #1;
        chk("col_dwait", dwait, 0);
        chk("col_dload", dload, 32'h1234_5678);
        chk("col_iwait_d", iwait, 1);
        step();
        ram_ready = 1'b0;
        #1;
        chk("col_ramaddr_i", ramaddr, 32'h44);
        chk("col_ramREN_i", ramREN, 1);
        chk("col_dwait_i", dwait, 1);
        step();
        ram_ready = 1'b1;
        ramload   = 32'h0000_00AA;
        iREN      = 1'b0;
        #1;
        chk("col_iwait_done", iwait, 0);
        chk("col_iload", iload, 32'hAA);
        step();
        ram_ready = 1'b0;
        #1;
        chk("col_ramREN_end", ramREN, 0);

        // Write path, dREN&&dWEN treated as write, mid-grant changes ignored
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'h0000_0200;
        dstore = 32'hDEAD_BEEF;
        step();
        #1;
        chk("wr_ramWEN", ramWEN, 1);
        chk("wr_ramREN", ramREN, 0);
        chk("wr_ramaddr", ramaddr, 32'h200);
        chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        dstore = 32'h1111_1111;
        daddr  = 32'h0000_0300;
        step();
        #1;
        chk("wr_ramstore_hold", ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr_hold", ramaddr, 32'h200);
        chk("wr_dwait_c2", dwait, 1);
        ram_ready = 1'b1;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        #1;
        chk("wr_dwait_done", dwait, 0);
        step();
        ram_ready = 1'b0;
        #1;
        chk("wr_ramWEN_end", ramWEN, 0);

        // Starvation bound: both pending, ram_ready every cycle
        iREN    = 1'b1;
        iaddr   = 32'h0000_0080;
        dREN    = 1'b1;
        daddr   = 32'h0000_0400;
        seq_exp = "DDDDIDDDDI";
        step();
        ram_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            if (seq_exp[g] == "D") begin
                chk($sformatf("stv_addr_%0d", g), ramaddr, 32'h400);
                chk($sformatf("stv_dwait_%0d", g), dwait, 0);
            end else begin
                chk($sformatf("stv_addr_%0d", g), ramaddr, 32'h80);
                chk($sformatf("stv_iwait_%0d", g), iwait, 0);
            end
            step();
        end
        iREN = 1'b0;
        dREN = 1'b0;
        step();
        ram_ready = 1'b0;
        #1;
        chk("stv_ramREN_end", ramREN, 0);

        // Dropped request: access still completes, then fetch is granted
        dREN  = 1'b1;
        daddr = 32'h0000_0500;
        step();
        dREN  = 1'b0;
        iREN  = 1'b1;
        iaddr = 32'h0000_0090;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("drop_ramREN_c%0d", c), ramREN, 1);
            chk($sformatf("drop_ramaddr_c%0d", c), ramaddr, 32'h500);
            chk($sformatf("drop_dwait_c%0d", c), dwait, 1);
            step();
        end
        ram_ready = 1'b1;
        #1;
        chk("drop_dwait_done", dwait, 0);
        step();
        ram_ready = 1'b0;
        #1;
        chk("drop_ramaddr_i", ramaddr, 32'h90);
        chk("drop_ramREN_i", ramREN, 1);
        chk("drop_iwait_i", iwait, 1);
        step();
        ram_ready = 1'b1;
        iREN      = 1'b0;
        #1;
        chk("drop_iwait_done", iwait, 0);
        step();
        ram_ready = 1'b0;
        #1;
        chk("drop_ramREN_end", ramREN, 0);

        // Asynchronous reset in the middle of a write grant
        dWEN   = 1'b1;
        daddr  = 32'h0000_0600;
        dstore = 32'h0000_CAFE;
        step();
        #1;
        chk("ar_ramWEN_pre", ramWEN, 1);
        #1;
        nRST = 1'b0;
        dWEN = 1'b0;
        #1;
        chk("ar_ramWEN", ramWEN, 0);
        chk("ar_ramREN", ramREN, 0);
        chk("ar_ramaddr", ramaddr, 0);
        chk("ar_ramstore", ramstore, 0);
        chk("ar_iwait", iwait, 1);
        chk("ar_dwait", dwait, 1);
        step();
        nRST = 1'b1;
        step();
        ram_ready = 1'b1;
        #1;
        chk("ar_post_dwait", dwait, 1);
        chk("ar_post_iwait", iwait, 1);
        step();
        ram_ready = 1'b0;
        #1;
        chk("ar_post_ramREN", ramREN, 0);
        chk("ar_post_ramWEN", ramWEN, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
